// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO write-side signals of the packet-locked FIFO write arbiter.
// master: the arbiter; slave: producers plus the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] din;
  logic [NUM_REQ-1:0]        last;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_din;

  modport master (
    input  req, din, last, fifo_full,
    output ack, gnt, busy, fifo_wr_en, fifo_din
  );

  modport slave (
    output req, din, last, fifo_full,
    input  ack, gnt, busy, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte FIFO write port among NUM_REQ producers.
// The owner keeps the FIFO until its byte flagged last is accepted.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    sel_idx;
  logic [IdxW-1:0]    cand;
  logic [IdxW-1:0]    owner_idx;
  logic               acc;

  // Walk candidates from farthest to nearest so the nearest set request after rr_ptr wins.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int k = int'(NUM_REQ); k > 0; k--) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (bus.req[cand]) sel_idx = cand;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (gnt_q[k]) owner_idx = IdxW'(k);
    end
  end

  // Gated by rst so nothing reaches the FIFO in the cycle the lock is dropped.
  assign acc = (state_q == StBurst) && !rst && bus.req[owner_idx] && !bus.fifo_full;

  assign bus.fifo_wr_en = acc;
  assign bus.ack        = acc ? gnt_q : '0;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q == StBurst);
  assign bus.fifo_din   = bus.din[owner_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          state_d        = StBurst;
        end
      end
      StBurst: begin
        if (acc && bus.last[owner_idx]) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = owner_idx;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table plus hand-built multi-cycle sequences.
// Each row drives inputs after the falling edge and checks outputs before the rising edge.
module tb_fifo_wr_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  last;
    logic        full;
    logic        chk;
    logic [3:0]  gnt;
    logic        busy;
    logic        wr;
    logic [3:0]  ack;
    logic [7:0]  dout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // fifo_din is compared whenever the arbiter is expected to be in BURST.
  task automatic row(input string name, input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.req       = v.req;
    bus.din       = v.din;
    bus.last      = v.last;
    bus.fifo_full = v.full;
    #1;
    if (v.chk) begin
      chk({name, ".gnt"}, 32'(bus.gnt), 32'(v.gnt));
      chk({name, ".busy"}, 32'(bus.busy), 32'(v.busy));
      chk({name, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(v.wr));
      chk({name, ".ack"}, 32'(bus.ack), 32'(v.ack));
      if (v.busy) chk({name, ".fifo_din"}, 32'(bus.fifo_din), 32'(v.dout));
      chk({name, ".inv_onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
      chk({name, ".inv_ack_in_gnt"}, 32'(bus.ack & ~bus.gnt), 32'd0);
      chk({name, ".inv_wr_full"}, 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);
      chk({name, ".inv_wr_ack"}, 32'(bus.fifo_wr_en), 32'(|bus.ack));
    end
  endtask

  task automatic do_reset();
    row("reset", '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
  endtask

  vec_t tbl[16];
  vec_t v;
  logic [3:0] cnt;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.req = '0;
    bus.din = '0;
    bus.last = '0;
    bus.fifo_full = 1'b0;

    // Fields: rst, req, din, last, full, chk, gnt, busy, wr, ack, dout
    tbl[0]  = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[2]  = '{1'b0, 4'h1, 32'hEEDD_CC11, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[3]  = '{1'b0, 4'h1, 32'hEEDD_CC11, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 8'h11};
    tbl[4]  = '{1'b0, 4'h1, 32'hEEDD_CC22, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 8'h22};
    tbl[5]  = '{1'b0, 4'h1, 32'hEEDD_CC33, 4'h1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 8'h33};
    tbl[6]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[7]  = '{1'b0, 4'h4, 32'h55A1_6677, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[8]  = '{1'b0, 4'h4, 32'h55A1_6677, 4'h0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 8'hA1};
    tbl[9]  = '{1'b0, 4'h4, 32'h55A2_6677, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 8'hA2};
    tbl[10] = '{1'b0, 4'h4, 32'h55A2_6677, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 8'hA2};
    tbl[11] = '{1'b0, 4'h4, 32'h55A2_6677, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 8'hA2};
    tbl[12] = '{1'b0, 4'h4, 32'h55A2_6677, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 8'hA2};
    tbl[13] = '{1'b0, 4'h4, 32'h55A2_6677, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 8'hA2};
    tbl[14] = '{1'b0, 4'h4, 32'h55A2_6677, 4'h4, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 8'hA2};
    tbl[15] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};

    for (int i = 0; i < 16; i++) begin
      row($sformatf("tbl%0d", i), tbl[i]);
    end

    // All four request 2-byte packets continuously: idle, B, B, idle, ... owners 0,1,2,3,0.
    do_reset();
    cnt = '0;
    for (int c = 0; c < 15; c++) begin
      v = '0;
      v.req = 4'hF;
      for (int i = 0; i < 4; i++) begin
        v.din[i*8 +: 8] = 8'(i * 16 + int'(cnt[i]));
        v.last[i]       = cnt[i];
      end
      v.chk = 1'b1;
      if (c % 3 != 0) begin
        v.gnt  = 4'(1 << ((c / 3) % 4));
        v.busy = 1'b1;
        v.wr   = 1'b1;
        v.ack  = v.gnt;
        v.dout = 8'(((c / 3) % 4) * 16 + (c % 3) - 1);
      end
      row($sformatf("rr%0d", c), v);
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) cnt[i] = ~cnt[i];
      end
    end

    // Owner 1 drops req for 3 cycles while requester 3 waits.
    do_reset();
    row("drop0", '{1'b0, 4'h2, 32'h0000_5100, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("drop1", '{1'b0, 4'h2, 32'h0000_5100, 4'h0, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 8'h51});
    for (int i = 0; i < 3; i++) begin
      row($sformatf("drop_gap%0d", i),
          '{1'b0, 4'h8, 32'h7E00_5200, 4'h8, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 8'h52});
    end
    row("drop5", '{1'b0, 4'hA, 32'h7E00_5200, 4'hA, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 8'h52});
    row("drop6", '{1'b0, 4'h8, 32'h7E00_0000, 4'h8, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("drop7", '{1'b0, 4'h8, 32'h7E00_0000, 4'h8, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 4'h8, 8'h7E});
    row("drop8", '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});

    // Single-byte packets from 1 and 2 together; leaves rr_ptr at 2.
    do_reset();
    row("sb0", '{1'b0, 4'h6, 32'h0062_6100, 4'h6, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("sb1", '{1'b0, 4'h6, 32'h0062_6100, 4'h6, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 8'h61});
    row("sb2", '{1'b0, 4'h4, 32'h0062_0000, 4'h4, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("sb3", '{1'b0, 4'h4, 32'h0062_0000, 4'h4, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 8'h62});
    row("sb4", '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});

    // Reset in requester 0's burst; without a pointer reset, 4'b1001 would grant requester 3.
    row("rst0", '{1'b0, 4'h1, 32'h0000_00C1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("rst1", '{1'b0, 4'h1, 32'h0000_00C1, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 8'hC1});
    row("rst2", '{1'b1, 4'h1, 32'h0000_00C2, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 8'hC2});
    row("rst3", '{1'b0, 4'h9, 32'hD300_00C2, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00});
    row("rst4", '{1'b0, 4'h9, 32'hD300_00C2, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 8'hC2});
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
